// File: rtl/pwm_seq_pkg.sv
// Shared constants for the PWM fade sequencer: register map, CTRL/STATUS bit
// positions and the sequencer FSM encoding.
package pwm_seq_pkg;

    localparam logic [3:0] REG_CTRL    = 4'd0;
    localparam logic [3:0] REG_STATUS  = 4'd1;
    localparam logic [3:0] REG_TARGET  = 4'd2;
    localparam logic [3:0] REG_STEP    = 4'd3;
    localparam logic [3:0] REG_HOLD    = 4'd4;
    localparam logic [3:0] REG_CURRENT = 4'd5;
    localparam logic [3:0] REG_START   = 4'd6;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_STATE_LSB = 2;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_RAMP   = 2'd1,
        FSM_FINISH = 2'd2
    } fsm_state_e;

    // Plain-vector aliases so state registers stay ordinary logic.
    localparam logic [1:0] ST_IDLE   = FSM_IDLE;
    localparam logic [1:0] ST_RAMP   = FSM_RAMP;
    localparam logic [1:0] ST_FINISH = FSM_FINISH;

endpackage

// File: rtl/pwm_fade_sequencer_if.sv
// Avalon-MM slave bus bundle between the Nios II data master and the sequencer.
interface pwm_fade_sequencer_if;

    // Fixed-latency Avalon: no waitrequest, a write is taken on the edge where
    // chipselect&&write is high, and readdata is valid one cycle after chipselect&&read.
    logic        avs_chipselect;
    logic [3:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;

    modport master (
        output avs_chipselect, avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_chipselect, avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/pwm_tick_gen.sv
// Free-running PWM timebase: CLK_DIV prescaler feeding a 0..PERIOD-1 tick counter.
module pwm_tick_gen #(
    parameter int CLK_DIV = 100,
    parameter int PERIOD  = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o,
    output logic boundary_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;

    assign tick_o     = (div_cnt_q == DIV_LAST);
    assign boundary_o = tick_o && (per_cnt_q == PER_LAST);

    always_comb begin
        div_cnt_d = tick_o ? '0 : div_cnt_q + 1'b1;
        per_cnt_d = per_cnt_q;
        if (tick_o) begin
            per_cnt_d = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            per_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            per_cnt_q <= per_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Avalon-MM fade sequencer: steps the PWM compare value toward a target, one step
// every HOLD periods, changing the compare output only on period boundaries.
module pwm_fade_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int CLK_DIV = 100,
    parameter int PERIOD  = 1000,
    parameter int DUTY_W  = 16
) (
    input  logic                csi_clk,
    input  logic                csi_reset_n,
    pwm_fade_sequencer_if.slave avs,
    output logic                ins_irq,
    output logic [DUTY_W-1:0]   coe_pwm_compare,
    output logic                coe_pwm_update,
    output logic                coe_period_start
);

    localparam logic [DUTY_W-1:0] PERIOD_V = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] ONE_V    = DUTY_W'(1);

    logic tick_unused;
    logic boundary;

    pwm_tick_gen #(
        .CLK_DIV (CLK_DIV),
        .PERIOD  (PERIOD)
    ) u_tick_gen (
        .clk_i      (csi_clk),
        .rst_ni     (csi_reset_n),
        .tick_o     (tick_unused),
        .boundary_o (boundary)
    );

    logic              enable_q, enable_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [1:0]        state_q, state_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [DUTY_W-1:0] step_q, step_d;
    logic [15:0]       hold_q, hold_d;
    logic [15:0]       hold_cnt_q, hold_cnt_d;
    logic [DUTY_W-1:0] cur_q, cur_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic [DUTY_W-1:0] cmp_q, cmp_d;
    logic              upd_q, upd_d;
    logic              irq_q;
    logic              pstart_q;
    logic [31:0]       rdata_q, rdata_d;

    logic        wr_en, rd_en;
    logic [31:0] wdata;
    logic        wr_ctrl, wr_status, wr_target, wr_step, wr_hold, wr_current, wr_start;
    logic        abort_req;
    logic        unused_wdata_hi;

    assign wr_en      = avs.avs_chipselect && avs.avs_write;
    assign rd_en      = avs.avs_chipselect && avs.avs_read;
    assign wdata      = avs.avs_writedata;
    assign wr_ctrl    = wr_en && (avs.avs_address == REG_CTRL);
    assign wr_status  = wr_en && (avs.avs_address == REG_STATUS);
    assign wr_target  = wr_en && (avs.avs_address == REG_TARGET);
    assign wr_step    = wr_en && (avs.avs_address == REG_STEP);
    assign wr_hold    = wr_en && (avs.avs_address == REG_HOLD);
    assign wr_current = wr_en && (avs.avs_address == REG_CURRENT);
    assign wr_start   = wr_en && (avs.avs_address == REG_START);
    assign unused_wdata_hi = ^wdata[31:16];

    // Clearing enable mid-fade is treated exactly like an explicit abort.
    assign abort_req = wr_ctrl && (wdata[CTRL_ABORT] || !wdata[CTRL_ENABLE]);

    logic [DUTY_W-1:0] wdata_duty, wdata_clamped;
    assign wdata_duty    = wdata[DUTY_W-1:0];
    assign wdata_clamped = (wdata_duty > PERIOD_V) ? PERIOD_V : wdata_duty;

    // Next level one step toward tgt_q; saturates at the target in both directions.
    logic [DUTY_W:0]   sum_w;
    logic [DUTY_W-1:0] diff_w, stepped;
    always_comb begin
        sum_w   = {1'b0, cur_q} + {1'b0, step_q};
        diff_w  = cur_q - tgt_q;
        stepped = tgt_q;
        if (cur_q < tgt_q) begin
            stepped = (sum_w >= {1'b0, tgt_q}) ? tgt_q : sum_w[DUTY_W-1:0];
        end else if (cur_q > tgt_q) begin
            stepped = (diff_w <= step_q) ? tgt_q : cur_q - step_q;
        end
    end

    always_comb begin
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        busy_d     = busy_q;
        state_d    = state_q;
        target_d   = target_q;
        step_d     = step_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        cur_d      = cur_q;
        tgt_d      = tgt_q;
        cmp_d      = cmp_q;
        upd_d      = 1'b0;

        if (wr_ctrl) begin
            enable_d = wdata[CTRL_ENABLE];
            irq_en_d = wdata[CTRL_IRQ_EN];
        end
        if (wr_status && wdata[STAT_DONE]) done_d = 1'b0;
        if (wr_target) target_d = wdata_clamped;
        if (wr_step)   step_d = (wdata_duty == '0) ? ONE_V : wdata_duty;
        if (wr_hold)   hold_d = (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];

        case (state_q)
            ST_IDLE: begin
                if (wr_current) cur_d = wdata_clamped;
                if (wr_start && enable_q && !abort_req) begin
                    state_d    = ST_RAMP;
                    tgt_d      = target_q;
                    hold_cnt_d = hold_q;
                    busy_d     = 1'b1;
                end
            end
            ST_RAMP: begin
                if (abort_req) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (wr_start) begin
                    tgt_d      = target_q;
                    hold_cnt_d = hold_q;
                end else if (boundary) begin
                    if (cur_q == tgt_q) begin
                        state_d = ST_FINISH;
                    end else if (hold_cnt_q <= 16'd1) begin
                        cur_d      = stepped;
                        hold_cnt_d = hold_q;
                        if (stepped == tgt_q) state_d = ST_FINISH;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 16'd1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // The PWM stage only ever sees a new compare value at a period boundary.
        if (boundary && (cur_d != cmp_q)) begin
            cmp_d = cur_d;
            upd_d = 1'b1;
        end
    end

    always_comb begin
        rdata_d = '0;
        case (avs.avs_address)
            REG_CTRL: begin
                rdata_d[CTRL_ENABLE] = enable_q;
                rdata_d[CTRL_IRQ_EN] = irq_en_q;
            end
            REG_STATUS: begin
                rdata_d[STAT_BUSY]             = busy_q;
                rdata_d[STAT_DONE]             = done_q;
                rdata_d[STAT_STATE_LSB +: 2]   = state_q;
            end
            REG_TARGET:  rdata_d[DUTY_W-1:0] = target_q;
            REG_STEP:    rdata_d[DUTY_W-1:0] = step_q;
            REG_HOLD:    rdata_d[15:0]       = hold_q;
            REG_CURRENT: rdata_d[DUTY_W-1:0] = cur_q;
            default:     rdata_d = '0;
        endcase
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
            target_q   <= '0;
            step_q     <= ONE_V;
            hold_q     <= 16'd1;
            hold_cnt_q <= 16'd0;
            cur_q      <= '0;
            tgt_q      <= '0;
            cmp_q      <= '0;
            upd_q      <= 1'b0;
            irq_q      <= 1'b0;
            pstart_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            state_q    <= state_d;
            target_q   <= target_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            cur_q      <= cur_d;
            tgt_q      <= tgt_d;
            cmp_q      <= cmp_d;
            upd_q      <= upd_d;
            irq_q      <= done_q && irq_en_q;
            pstart_q   <= boundary;
            if (rd_en) rdata_q <= rdata_d;
        end
    end

    assign avs.avs_readdata = rdata_q;
    assign ins_irq          = irq_q;
    assign coe_pwm_compare  = cmp_q;
    assign coe_pwm_update   = upd_q;
    assign coe_period_start = pstart_q;

endmodule
